// File: rtl/counter_pkg.sv
// Shared types and defaults for the counter library (up and down counters).
// Holds the control FSM state enum, mode encodings and default sizes.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 16;

endpackage

// File: rtl/count_prescaler.sv
// Tick generator: counts enabled cycles 0..PRESCALE-1, ticks on the last.
// Ports: clk, rst (async high), en, clr (sync clear), tick (comb).
module count_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LASTP = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  assign tick = en & (pcnt == LASTP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= (pcnt == LASTP) ? '0 : pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/sync_up_counter.sv
// Up counter 0..MODULUS-1 with enable, clamped load, tc carry, one-shot FSM.
// Ports: clk, rst (async high), en, load, load_val, mode, clr_done ->
//   count (reg), tc (comb), done (reg).
// Optional prescaler: define SYNC_UP_COUNTER_PRESCALE_EN.
module sync_up_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MODULUS  = DEF_MODULUS,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  input  logic             clr_done,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
    $error("sync_up_counter: MODULUS out of range");
  end
  if (PRESCALE < 1) begin : g_bad_ps
    $error("sync_up_counter: PRESCALE must be >= 1");
  end

  state_t           state, state_n;
  logic [WIDTH-1:0] count_n;
  logic             done_n;
  logic             step;
  logic [WIDTH-1:0] ld_val;
  logic             at_last;

`ifdef SYNC_UP_COUNTER_PRESCALE_EN
  logic ps_tick;

  // Prescaler is frozen while halted so a resume starts a fresh period.
  count_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_ps (
    .clk (clk),
    .rst (rst),
    .en  (en & (state != HALT)),
    .clr (load | clr_done),
    .tick(ps_tick)
  );

  assign step = ps_tick;
`else
  assign step = en;
`endif

  assign at_last = (count == LAST);
  assign ld_val  = (32'(load_val) > 32'(MODULUS - 1)) ? LAST : load_val;
  assign tc      = at_last & step & (state != HALT);

  always_comb begin
    state_n = state;
    count_n = count;
    done_n  = done;
    unique case (state)
      IDLE, COUNT: begin
        if (load) begin
          count_n = ld_val;
          done_n  = 1'b0;
          state_n = COUNT;
        end else if (step) begin
          state_n = COUNT;
          if (!at_last) begin
            count_n = count + 1'b1;
          end else if (mode == MODE_ONESHOT) begin
            state_n = HALT;
            done_n  = 1'b1;
          end else begin
            count_n = '0;
          end
        end
      end
      HALT: begin
        if (load) begin
          count_n = ld_val;
          done_n  = 1'b0;
          state_n = COUNT;
        end else if (clr_done) begin
          count_n = '0;
          done_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        count_n = '0;
        done_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_sync_up_counter.sv
// Directed bench for sync_up_counter (WIDTH=4, MODULUS=10, PRESCALE=4).
// Hand-computed expectations; summary line at the end.
module tb_sync_up_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       mode;
  logic       clr_done;
  logic [3:0] count;
  logic       tc;
  logic       done;

  int total = 0;
  int bad   = 0;

  sync_up_counter #(
    .WIDTH   (4),
    .MODULUS (10),
    .PRESCALE(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .mode    (mode),
    .clr_done(clr_done),
    .count   (count),
    .tc      (tc),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en       = 1'b0;
    load     = 1'b0;
    load_val = 4'd0;
    mode     = 1'b0;
    clr_done = 1'b0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    rst = 1'b0;
    edge1();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (count !== 4'd0 || done !== 1'b0 || tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: count=%0d done=%0b tc=%0b need 0/0/0",
               count, done, tc);
    end
    #99;
    rst = 1'b0;
    edge1();
    total++;
    if (count !== 4'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: count=%0d done=%0b need 0/0", count, done);
    end
  endtask

  task automatic test_count();
    int e;
    e    = 0;
    mode = 1'b0;
    en   = 1'b1;
    #1;
    for (int i = 0; i < 11; i++) begin
      total++;
      if (count !== 4'(e) || tc !== (e == 9)) begin
        bad++;
        $display("FAIL count_%0d: count=%0d tc=%0b need %0d/%0b",
                 i, count, tc, e, (e == 9));
      end
      edge1();
      e = (e + 1) % 10;
    end
    en = 1'b0;
    #1;
    total++;
    if (count !== 4'd1 || tc !== 1'b0) begin
      bad++;
      $display("FAIL count_end: count=%0d tc=%0b need 1/0", count, tc);
    end
  endtask

  task automatic test_oneshot();
    pulse_reset();
    mode = 1'b1;
    en   = 1'b1;
    repeat (9) edge1();
    total++;
    if (count !== 4'd9 || tc !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_last: count=%0d tc=%0b done=%0b need 9/1/0",
               count, tc, done);
    end
    edge1();
    total++;
    if (count !== 4'd9 || tc !== 1'b0 || done !== 1'b1) begin
      bad++;
      $display("FAIL oneshot_halt: count=%0d tc=%0b done=%0b need 9/0/1",
               count, tc, done);
    end
    for (int i = 0; i < 20; i++) begin
      edge1();
      total++;
      if (count !== 4'd9 || tc !== 1'b0 || done !== 1'b1) begin
        bad++;
        $display("FAIL oneshot_hold_%0d: count=%0d tc=%0b done=%0b need 9/0/1",
                 i, count, tc, done);
      end
    end
  endtask

  task automatic test_halt_exit();
    clr_done = 1'b1;
    edge1();
    clr_done = 1'b0;
    total++;
    if (count !== 4'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL halt_clr: count=%0d done=%0b need 0/0", count, done);
    end
    edge1();
    total++;
    if (count !== 4'd1) begin
      bad++;
      $display("FAIL halt_restart: count=%0d need 1", count);
    end
    repeat (9) edge1();
    total++;
    if (count !== 4'd9 || done !== 1'b1) begin
      bad++;
      $display("FAIL halt_again: count=%0d done=%0b need 9/1", count, done);
    end
    load     = 1'b1;
    load_val = 4'd3;
    clr_done = 1'b1;
    edge1();
    load     = 1'b0;
    clr_done = 1'b0;
    total++;
    if (count !== 4'd3 || done !== 1'b0) begin
      bad++;
      $display("FAIL halt_load: count=%0d done=%0b need 3/0", count, done);
    end
    edge1();
    total++;
    if (count !== 4'd4) begin
      bad++;
      $display("FAIL halt_resume: count=%0d need 4", count);
    end
    en       = 1'b0;
    clr_done = 1'b1;
    edge1();
    clr_done = 1'b0;
    total++;
    if (count !== 4'd4 || done !== 1'b0) begin
      bad++;
      $display("FAIL clr_outside: count=%0d done=%0b need 4/0", count, done);
    end
  endtask

  task automatic test_load();
    mode     = 1'b0;
    en       = 1'b1;
    load     = 1'b1;
    load_val = 4'd5;
    edge1();
    load = 1'b0;
    total++;
    if (count !== 4'd5) begin
      bad++;
      $display("FAIL load_5: count=%0d need 5", count);
    end
    edge1();
    total++;
    if (count !== 4'd6) begin
      bad++;
      $display("FAIL load_next: count=%0d need 6", count);
    end
    load     = 1'b1;
    load_val = 4'd12;
    edge1();
    load = 1'b0;
    en   = 1'b0;
    total++;
    if (count !== 4'd9) begin
      bad++;
      $display("FAIL load_clamp: count=%0d need 9", count);
    end
    edge1();
    total++;
    if (count !== 4'd9 || tc !== 1'b0) begin
      bad++;
      $display("FAIL load_hold: count=%0d tc=%0b need 9/0", count, tc);
    end
    en = 1'b1;
    #1;
    total++;
    if (tc !== 1'b1) begin
      bad++;
      $display("FAIL tc_wrap: tc=%0b need 1", tc);
    end
    edge1();
    en = 1'b0;
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL load_wrap: count=%0d need 0", count);
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    mode = 1'b0;
    en   = 1'b1;
    repeat (7) edge1();
    total++;
    if (count !== 4'd7) begin
      bad++;
      $display("FAIL arst_pre: count=%0d need 7", count);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (count !== 4'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL arst_mid: count=%0d done=%0b need 0/0", count, done);
    end
    #1;
    rst  = 1'b0;
    mode = 1'b1;
    repeat (10) edge1();
    total++;
    if (count !== 4'd9 || done !== 1'b1) begin
      bad++;
      $display("FAIL arst_halt_pre: count=%0d done=%0b need 9/1", count, done);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (count !== 4'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL arst_halt: count=%0d done=%0b need 0/0", count, done);
    end
    #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_prescale();
    pulse_reset();
    en = 1'b1;
    repeat (3) edge1();
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL ps_wait: count=%0d need 0", count);
    end
    edge1();
    total++;
    if (count !== 4'd1) begin
      bad++;
      $display("FAIL ps_step1: count=%0d need 1", count);
    end
    repeat (2) edge1();
    en = 1'b0;
    repeat (3) edge1();
    en = 1'b1;
    edge1();
    total++;
    if (count !== 4'd1) begin
      bad++;
      $display("FAIL ps_gap: count=%0d need 1", count);
    end
    edge1();
    total++;
    if (count !== 4'd2) begin
      bad++;
      $display("FAIL ps_step2: count=%0d need 2", count);
    end
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
`ifdef SYNC_UP_COUNTER_PRESCALE_EN
    test_prescale();
`else
    test_count();
    test_oneshot();
    test_halt_exit();
    test_load();
    test_async_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
